// File: rtl/sr_pkg.sv
// sr_pkg: shared op encodings and controller FSM states for the SR flag bank.
package sr_pkg;
  typedef enum logic [1:0] {OP_NOP = 2'b00, OP_SET = 2'b01, OP_CLR = 2'b10, OP_TGL = 2'b11} op_e;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRIVE} state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first valid requester at or after ptr_i, wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] win_o
);
  always_comb begin
    int j;
    win_o = '0;
    // scanning from the farthest offset down leaves the nearest valid one as winner
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr_i) + k) % N;
      if (valid_i[j]) win_o = PW'(j);
    end
    gnt_o = |valid_i ? N'(1) << win_o : '0;
  end
endmodule

// File: rtl/sr_ff.sv
// sr_ff: single SR flag flop; reset wins, s sets, r clears, s=r=0 holds.
module sr_ff (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  output logic q
);
  always_ff @(posedge clk)
    q <= rst ? 1'b0 : s ? 1'b1 : r ? 1'b0 : q;
endmodule

// File: rtl/sr_bank_ctrl.sv
// sr_bank_ctrl: round-robin shared controller issuing SET/CLEAR/TOGGLE/NOP onto a bank of SR flops.
module sr_bank_ctrl
  import sr_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int NUM_FF = 8,
  parameter int IDX_W  = (NUM_FF > 1) ? $clog2(NUM_FF) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [2*N_REQ-1:0]     req_op,
  input  logic [IDX_W*N_REQ-1:0] req_idx,
  output logic [N_REQ-1:0]       req_ack,
  output logic                   req_err,
  output logic                   busy,
  output logic [NUM_FF-1:0]      q
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  state_e            state_q;
  op_e               op_q;
  logic [PW-1:0]     ptr_q, win;
  logic [N_REQ-1:0]  gnt, gnt_q, ack_q;
  logic [IDX_W-1:0]  idx_q;
  logic [NUM_FF-1:0] oh, s_d, r_d, s_q, r_q;
  logic              oor, err_q;

  rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb (
    .valid_i(req_valid),
    .ptr_i  (ptr_q),
    .gnt_o  (gnt),
    .win_o  (win)
  );

  // an out-of-range idx shifts the one-hot off the top, so s/r stay zero for it
  always_comb begin
    oh  = NUM_FF'(1) << idx_q;
    oor = int'(idx_q) >= NUM_FF;
    s_d = op_q == OP_SET ? oh : op_q == OP_TGL ? oh & ~q : '0;
    r_d = op_q == OP_CLR ? oh : op_q == OP_TGL ? oh & q : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      op_q    <= OP_NOP;
      idx_q   <= '0;
      s_q     <= '0;
      r_q     <= '0;
      err_q   <= 1'b0;
      ack_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (|req_valid) begin
          gnt_q   <= gnt;
          op_q    <= op_e'(req_op[win*2 +: 2]);
          idx_q   <= req_idx[win*IDX_W +: IDX_W];
          ptr_q   <= (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
          state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          s_q     <= s_d;
          r_q     <= r_d;
          err_q   <= oor;
          ack_q   <= gnt_q;
          state_q <= ST_DRIVE;
        end
        default: begin
          s_q     <= '0;
          r_q     <= '0;
          err_q   <= 1'b0;
          ack_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_FF; g++) begin : g_bank
    sr_ff u_ff (.clk(clk), .rst(rst), .s(s_q[g]), .r(r_q[g]), .q(q[g]));
  end

  assign req_ack = ack_q;
  assign req_err = err_q;
  assign busy    = state_q != ST_IDLE;
endmodule

// File: tb/tb_sr_bank_ctrl.sv
// tb_sr_bank_ctrl: directed and random traffic scored against a behavioural bank model.
module tb_sr_bank_ctrl;
  localparam int N_REQ  = 4;
  localparam int NUM_FF = 6;
  localparam int IDX_W  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N_REQ-1:0]       req_valid = '0;
  logic [2*N_REQ-1:0]     req_op    = '0;
  logic [IDX_W*N_REQ-1:0] req_idx   = '0;
  logic [N_REQ-1:0]       req_ack;
  logic                   req_err, busy;
  logic [NUM_FF-1:0]      q;

  sr_bank_ctrl #(.N_REQ(N_REQ), .NUM_FF(NUM_FF), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_idx(req_idx),
    .req_ack(req_ack), .req_err(req_err), .busy(busy), .q(q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N_REQ-1:0]  ack;
    logic              err;
    logic [NUM_FF-1:0] q;
    int                cyc;
  } exp_t;

  exp_t sb[$];
  int nvec = 0, nerr = 0, cyc = 0;
  logic rand_en = 1'b0;
  logic [N_REQ-1:0] last_ack = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: an idle controller grants the first valid requester at or after
  // its pointer, is then occupied for three cycles, and acks two cycles after the grant.
  int m_ptr = 0, m_free = 0;
  logic [NUM_FF-1:0] m_q = '0;
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      m_ptr  = 0;
      m_q    = '0;
      m_free = cyc + 1;
    end else if (cyc >= m_free && req_valid != 0) begin
      int w, idx;
      logic [1:0] op;
      logic e;
      w = -1;
      for (int k = 0; k < N_REQ; k++)
        if (w < 0 && req_valid[(m_ptr + k) % N_REQ]) w = (m_ptr + k) % N_REQ;
      op  = req_op[2*w +: 2];
      idx = int'(req_idx[IDX_W*w +: IDX_W]);
      e   = idx >= NUM_FF;
      if (!e)
        case (op)
          2'b01:   m_q[idx] = 1'b1;
          2'b10:   m_q[idx] = 1'b0;
          2'b11:   m_q[idx] = ~m_q[idx];
          default: ;
        endcase
      sb.push_back('{ack: N_REQ'(1) << w, err: e, q: m_q, cyc: cyc + 2});
      m_ptr  = (w + 1) % N_REQ;
      m_free = cyc + 3;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT acks; checks q the cycle after.
  logic pend = 1'b0;
  int pend_cyc = 0;
  logic [NUM_FF-1:0] pend_q = '0;
  int wc [N_REQ];
  always @(negedge clk) begin
    if (rst) begin
      pend     = 1'b0;
      last_ack = '0;
      for (int i = 0; i < N_REQ; i++) wc[i] = 0;
    end else begin
      chk("s_and_r_exclusive", 32'(dut.s_q & dut.r_q), 32'd0);
      if (pend && cyc == pend_cyc) begin
        chk("q_after_ack", 32'(q), 32'(pend_q));
        pend = 1'b0;
      end
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        nvec++;
        nerr++;
        $display("FAIL missing_ack: no ack by cycle %0d, expected ack 0x%0h", sb[0].cyc, sb[0].ack);
        void'(sb.pop_front());
      end
      if (req_ack != 0) begin
        if (sb.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_ack: got ack 0x%0h with nothing outstanding", req_ack);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("ack_onehot", 32'(req_ack), 32'(e.ack));
          chk("ack_err", 32'(req_err), 32'(e.err));
          chk("ack_cycle", cyc, e.cyc);
          pend     = 1'b1;
          pend_cyc = cyc + 1;
          pend_q   = e.q;
        end
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (req_ack[i]) begin
          chk("wait_bound", 32'(wc[i] <= 3*N_REQ), 32'd1);
          wc[i] = 0;
        end else if (req_valid[i]) begin
          wc[i]++;
          if (wc[i] == 3*N_REQ + 1) begin
            nvec++;
            nerr++;
            $display("FAIL starvation: requester %0d waited %0d cycles, limit %0d", i, wc[i], 3*N_REQ);
          end
        end else wc[i] = 0;
      end
      last_ack = req_ack;
    end
  end

  // One clock step for the driver: retire acked requests, optionally issue random ones.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N_REQ; i++) begin
      if (last_ack[i]) req_valid[i] = 1'b0;
      else if (rand_en && !req_valid[i] && $urandom_range(2) == 0) begin
        req_valid[i]             = 1'b1;
        req_op[2*i +: 2]         = 2'($urandom_range(3));
        req_idx[IDX_W*i +: IDX_W] = 3'($urandom_range(7));
      end
    end
  endtask

  task automatic issue(input int i, input logic [1:0] op, input logic [2:0] idx);
    req_valid[i]              = 1'b1;
    req_op[2*i +: 2]          = op;
    req_idx[IDX_W*i +: IDX_W] = idx;
  endtask

  task automatic do_op(input int i, input logic [1:0] op, input logic [2:0] idx,
                       input logic err, input logic [NUM_FF-1:0] qx);
    tick();
    issue(i, op, idx);
    tick();
    tick();
    @(negedge clk);
    chk("dir_ack", 32'(req_ack), 32'(N_REQ'(1) << i));
    chk("dir_err", 32'(req_err), 32'(err));
    tick();
    @(negedge clk);
    chk("dir_q", 32'(q), 32'(qx));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((req_valid != 0 || sb.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    chk("drain_done", 32'(n < 200), 32'd1);
    repeat (3) tick();
  endtask

  initial begin
    tick();
    tick();
    @(negedge clk);
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(req_ack), 32'd0);
    tick();
    rst = 1'b0;
    do_op(0, 2'b01, 3'd5, 1'b0, 6'h20);
    do_op(1, 2'b10, 3'd5, 1'b0, 6'h00);
    do_op(0, 2'b11, 3'd2, 1'b0, 6'h04);
    do_op(0, 2'b11, 3'd2, 1'b0, 6'h00);
    do_op(3, 2'b01, 3'd1, 1'b0, 6'h02);
    do_op(2, 2'b01, 3'd7, 1'b1, 6'h02);
    do_op(1, 2'b00, 3'd1, 1'b0, 6'h02);
    drain();
    // reset lands on the DRIVE cycle of a SET idx 3: op is lost and the bank clears
    tick();
    issue(0, 2'b01, 3'd3);
    tick();
    tick();
    rst       = 1'b1;
    req_valid = '0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_q", 32'(q), 32'h0);
    chk("abort_ack", 32'(req_ack), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    // all requesters valid out of reset: grants rotate 0,1,2,3 three cycles apart
    tick();
    rst = 1'b1;
    for (int i = 0; i < N_REQ; i++) issue(i, 2'b01, 3'(i));
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      repeat (k == 0 ? 2 : 3) tick();
      @(negedge clk);
      chk("rr_order", 32'(req_ack), 32'(N_REQ'(1) << k));
    end
    tick();
    @(negedge clk);
    chk("rr_final_q", 32'(q), 32'h0F);
    drain();
    rand_en = 1'b1;
    repeat (10000) tick();
    rand_en = 1'b0;
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
